// File: rtl/seq_ctrl_pkg.sv
// Shared definitions for the seq_ctrl sequencing controller.
package seq_ctrl_pkg;

    // Default sizing: pattern length and step/hit counter width
    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned CNT_W_DEF  = 5;

    // Controller state encodings
    localparam int unsigned ST_W = 2;
    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_RUN  = 2'd1;
    localparam logic [ST_W-1:0] ST_FIN  = 2'd2;

    // Datapath state counted as a detection of "110"
    localparam logic [1:0] S11 = 2'b11;

endpackage

// File: rtl/seq_nsg.sv
// Combinational next-state generator for the 2-bit datapath (q1,q0,x -> d1,d0).
module seq_nsg (
    input  logic q1,
    input  logic q0,
    input  logic x,
    output logic d1,
    output logic d0
);

    // Fixed next-state table
    always_comb begin
        d1 = 1'b0;
        d0 = 1'b0;
        case ({q1, q0})
            2'b00: begin d1 = 1'b0; d0 = x;    end
            2'b01: begin d1 = x;    d0 = 1'b0; end
            2'b10: begin d1 = 1'b1; d0 = ~x;   end
            2'b11: begin d1 = 1'b0; d0 = x;    end
            default: begin d1 = 1'b0; d0 = 1'b0; end
        endcase
    end

endmodule

// File: rtl/seq_ctrl.sv
// Sequencing controller: streams a captured pattern LSB-first through seq_nsg,
// counts entries into state 11 and signals completion with a done pulse.
// Optional feature macro: SEQ_CTRL_ABORT_EN (adds abort input / aborted output).
module seq_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic [DATA_W-1:0] pattern,
`ifdef SEQ_CTRL_ABORT_EN
    input  logic              abort,
`endif
    output logic              busy,
    output logic              done,
    output logic [1:0]        q,
    output logic [CNT_W-1:0]  hits
`ifdef SEQ_CTRL_ABORT_EN
    ,
    output logic              aborted
`endif
);

    logic [ST_W-1:0]   state;
    logic [ST_W-1:0]   state_nxt;
    logic [DATA_W-1:0] shift;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  len_clamp;
    logic              load;
    logic              step;
    logic              abort_req;
    logic              d1;
    logic              d0;
    logic [1:0]        q_nxt;

`ifdef SEQ_CTRL_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Requested length limited to the pattern width
    always_comb begin
        len_clamp = len;
        if (len > CNT_W'(DATA_W)) begin
            len_clamp = CNT_W'(DATA_W);
        end
    end

    seq_nsg u_nsg (
        .q1 (q[1]),
        .q0 (q[0]),
        .x  (shift[0]),
        .d1 (d1),
        .d0 (d0)
    );

    assign q_nxt = {d1, d0};

    // Controller state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = (len_clamp != '0) ? ST_RUN : ST_FIN;
                end
            end
            ST_RUN: begin
                if (abort_req) begin
                    state_nxt = ST_IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state_nxt = ST_FIN;
                    end
                end
            end
            ST_FIN: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath: pattern shifter, step counter, state pair and hit counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift <= '0;
            cnt   <= '0;
            q     <= 2'b00;
            hits  <= '0;
        end else if (load) begin
            shift <= pattern;
            cnt   <= len_clamp;
            q     <= 2'b00;
            hits  <= '0;
        end else if (step) begin
            shift <= shift >> 1;
            cnt   <= cnt - CNT_W'(1);
            q     <= q_nxt;
            if (q_nxt == S11) begin
                hits <= hits + CNT_W'(1);
            end
        end
    end

    // Status outputs, one cycle behind the controller state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state != ST_IDLE);
            done <= (state == ST_FIN);
        end
    end

`ifdef SEQ_CTRL_ABORT_EN
    // Sticky abort flag, cleared by the next accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aborted <= 1'b0;
        end else if (load) begin
            aborted <= 1'b0;
        end else if ((state == ST_RUN) && abort_req) begin
            aborted <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_seq_ctrl.sv
// Directed bench for seq_ctrl with a scoreboard of expected run results.
module tb_seq_ctrl;

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] len;
    logic [DW-1:0] pattern;
    logic          busy;
    logic          done;
    logic [1:0]    q;
    logic [CW-1:0] hits;
`ifdef SEQ_CTRL_ABORT_EN
    logic          abort;
    logic          aborted;
`endif

    typedef struct {
        logic [1:0]    q;
        logic [CW-1:0] hits;
        int            lat;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    seq_ctrl #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .len     (len),
        .pattern (pattern),
`ifdef SEQ_CTRL_ABORT_EN
        .abort   (abort),
        .aborted (aborted),
`endif
        .busy    (busy),
        .done    (done),
        .q       (q),
        .hits    (hits)
    );

    // Reference next-state table
    function automatic logic [1:0] ref_nsg(input logic [1:0] s, input logic x);
        case ({s, x})
            3'b000: return 2'b00;
            3'b001: return 2'b01;
            3'b010: return 2'b00;
            3'b011: return 2'b10;
            3'b100: return 2'b11;
            3'b101: return 2'b10;
            3'b110: return 2'b00;
            default: return 2'b01;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete run; second_at > 0 pulses an extra start at that edge
    task automatic run(input logic [DW-1:0] pat, input logic [CW-1:0] l, input int second_at);
        exp_t       e;
        exp_t       got;
        logic [1:0] tr[0:DW];
        logic [1:0] qm;
        logic [CW-1:0] hm;
        int         lc;
        int         n;
        bit         busy_ok;
        lc = (int'(l) > int'(DW)) ? int'(DW) : int'(l);
        qm = 2'b00;
        hm = '0;
        tr[0] = 2'b00;
        for (int i = 0; i < lc; i++) begin
            qm = ref_nsg(qm, pat[i]);
            if (qm == 2'b11) hm = hm + 5'd1;
            tr[i+1] = qm;
        end
        e.q = qm;
        e.hits = hm;
        e.lat = lc + 1;
        sb.push_back(e);

        pattern = pat;
        len     = l;
        start   = 1'b1;
        tick;
        start   = 1'b0;
        chk("q_clear", 32'(q), 32'(0));
        chk("hits_clear", 32'(hits), 32'(0));

        n = 0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && n < 60) begin
            if (second_at == n + 1) begin
                start   = 1'b1;
                len     = 5'd1;
                pattern = '0;
            end
            tick;
            n++;
            start = 1'b0;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (n <= lc) chk("q_step", 32'(q), 32'(tr[n]));
        end
        chk("done_seen", 32'(done), 32'(1));
        chk("latency", 32'(n), 32'(e.lat));
        chk("busy_run", 32'(busy_ok), 32'(1));
        chk("sb_nonempty", 32'(sb.size()), 32'(1));
        if (sb.size() != 0) begin
            got = sb.pop_front();
            chk("q_final", 32'(q), 32'(got.q));
            chk("hits_final", 32'(hits), 32'(got.hits));
        end
        tick;
        chk("done_pulse", 32'(done), 32'(0));
        chk("busy_idle", 32'(busy), 32'(0));
        chk("q_hold", 32'(q), 32'(e.q));
        chk("hits_hold", 32'(hits), 32'(e.hits));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit no_done;
        rst     = 1'b1;
        start   = 1'b0;
        len     = '0;
        pattern = '0;
`ifdef SEQ_CTRL_ABORT_EN
        abort   = 1'b0;
`endif
        tick;
        tick;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_q", 32'(q), 32'(0));
        chk("rst_hits", 32'(hits), 32'(0));
        rst = 1'b0;
        tick;

        // x = 1,1,0,0
        run(16'h0003, 5'd4, 0);
        // 9 bits of 0xDB, three "110" detections
        run(16'h00DB, 5'd9, 0);
        // zero length
        run(16'h00FF, 5'd0, 0);
        // clamped length with an ignored start at edge 3
        run(16'hFFFF, 5'd20, 3);

        // asynchronous reset mid-run
        pattern = 16'h0003;
        len     = 5'd4;
        start   = 1'b1;
        tick;
        start   = 1'b0;
        tick;
        tick;
        tick;
        chk("pre_rst_q", 32'(q), 32'(2'b11));
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'(0));
        chk("arst_done", 32'(done), 32'(0));
        chk("arst_q", 32'(q), 32'(0));
        chk("arst_hits", 32'(hits), 32'(0));
        #1;
        rst = 1'b0;
        tick;
        chk("post_rst_busy", 32'(busy), 32'(0));
        run(16'h0003, 5'd4, 0);

`ifdef SEQ_CTRL_ABORT_EN
        // abort after four steps
        pattern = 16'h00DB;
        len     = 5'd9;
        start   = 1'b1;
        tick;
        start   = 1'b0;
        for (int i = 0; i < 4; i++) tick;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("abort_flag", 32'(aborted), 32'(1));
        chk("abort_q", 32'(q), 32'(2'b01));
        chk("abort_hits", 32'(hits), 32'(1));
        no_done = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (done !== 1'b0) no_done = 1'b0;
        end
        chk("abort_no_done", 32'(no_done), 32'(1));
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_q_frozen", 32'(q), 32'(2'b01));
        run(16'h00DB, 5'd9, 0);
        chk("aborted_cleared", 32'(aborted), 32'(0));
`else
        no_done = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (done !== 1'b0) no_done = 1'b0;
        end
        chk("idle_no_done", 32'(no_done), 32'(1));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
